// File: rtl/clk_div_pkg.sv
// Shared constants and channel-state encoding for the multi-channel clock divider.
package clk_div_pkg;

  localparam int DIV_W_DEFAULT   = 8;
  localparam int DEF_DIV_DEFAULT = 50;
  localparam int MIN_DIV         = 2;

  typedef enum logic [1:0] {
    CH_IDLE,
    CH_RUN,
    CH_STOPPING
  } chan_state_e;

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: period counter, run/stop state, shadow ratio and tick pulse.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int DIV_W   = DIV_W_DEFAULT,
  parameter int DEF_DIV = DEF_DIV_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_en,
  input  logic             i_wr,
  input  logic [DIV_W-1:0] i_wr_val,
  output logic             o_clk,
  output logic             o_tick,
  output logic             o_pend
);

  chan_state_e      state;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_act;
  logic [DIV_W-1:0] div_shadow;
  logic             last;
  logic [DIV_W-1:0] cnt_nxt;
  logic [DIV_W:0]   half;
  logic             high_nxt;

  // Extra bit on the half-period so (D+1)>>1 cannot overflow at the maximum ratio.
  assign last     = (cnt == div_act - DIV_W'(1));
  assign cnt_nxt  = cnt + DIV_W'(1);
  assign half     = ({1'b0, div_act} + (DIV_W + 1)'(1)) >> 1;
  assign high_nxt = ({1'b0, cnt_nxt} < half);

  // A period boundary either restarts (picking up any pending ratio) or parks in IDLE;
  // a write is handled after the boundary so it wins over the shadow it replaces.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= CH_IDLE;
      cnt        <= '0;
      div_act    <= DIV_W'(DEF_DIV);
      div_shadow <= '0;
      o_clk      <= 1'b0;
      o_tick     <= 1'b0;
      o_pend     <= 1'b0;
    end else begin
      o_tick <= 1'b0;
      case (state)
        CH_IDLE: begin
          if (i_en) begin
            state  <= CH_RUN;
            cnt    <= '0;
            o_clk  <= 1'b1;
            o_tick <= 1'b1;
            if (o_pend) begin
              div_act <= div_shadow;
              o_pend  <= 1'b0;
            end
          end
        end
        default: begin
          if (last) begin
            if (i_en) begin
              state  <= CH_RUN;
              cnt    <= '0;
              o_clk  <= 1'b1;
              o_tick <= 1'b1;
              if (o_pend) begin
                div_act <= div_shadow;
                o_pend  <= 1'b0;
              end
            end else begin
              state <= CH_IDLE;
              cnt   <= '0;
              o_clk <= 1'b0;
            end
          end else begin
            state <= i_en ? CH_RUN : CH_STOPPING;
            cnt   <= cnt_nxt;
            o_clk <= high_nxt;
          end
        end
      endcase

      if (i_wr) begin
        if (state == CH_IDLE) begin
          div_act <= i_wr_val;
          o_pend  <= 1'b0;
        end else begin
          div_shadow <= i_wr_val;
          o_pend     <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/clk_divider_mc.sv
// Multi-channel clock divider: decodes ratio writes, flags bad ones, and hosts NCH channels.
module clk_divider_mc
  import clk_div_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int DIV_W   = DIV_W_DEFAULT,
  parameter int DEF_DIV = DEF_DIV_DEFAULT,
  localparam int SEL_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [NCH-1:0]   i_en,
  input  logic             i_div_wr,
  input  logic [SEL_W-1:0] i_div_sel,
  input  logic [DIV_W-1:0] i_div_val,
  output logic [NCH-1:0]   o_clk,
  output logic [NCH-1:0]   o_tick,
  output logic [NCH-1:0]   o_pend,
  output logic             o_err
);

  logic sel_ok;
  logic val_ok;
  logic wr_ok;

  assign sel_ok = (32'(i_div_sel) < 32'(NCH));
  assign val_ok = (i_div_val >= DIV_W'(MIN_DIV));
  assign wr_ok  = i_div_wr && sel_ok && val_ok;

  // Rejected writes never reach a channel; they only raise a one-cycle error pulse.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_err <= 1'b0;
    end else begin
      o_err <= i_div_wr && !wr_ok;
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_chan
    clk_div_chan #(
      .DIV_W   (DIV_W),
      .DEF_DIV (DEF_DIV)
    ) u_chan (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_en     (i_en[k]),
      .i_wr     (wr_ok && (i_div_sel == SEL_W'(k))),
      .i_wr_val (i_div_val),
      .o_clk    (o_clk[k]),
      .o_tick   (o_tick[k]),
      .o_pend   (o_pend[k])
    );
  end

endmodule

// File: tb/tb_clk_divider_mc.sv
// Self-checking bench for clk_divider_mc: vector table plus multi-cycle scenario sequences.
module tb_clk_divider_mc;

  localparam int NCH   = 6;
  localparam int DIV_W = 8;
  localparam int SEL_W = 3;
  localparam int NVEC  = 14;

  typedef struct {
    logic             rst;
    logic [NCH-1:0]   en;
    logic             wr;
    logic [SEL_W-1:0] sel;
    logic [DIV_W-1:0] val;
    logic [NCH-1:0]   e_clk;
    logic [NCH-1:0]   e_tick;
    logic [NCH-1:0]   e_pend;
    logic             e_err;
  } vec_t;

  logic             i_clk = 1'b0;
  logic             i_reset;
  logic [NCH-1:0]   i_en;
  logic             i_div_wr;
  logic [SEL_W-1:0] i_div_sel;
  logic [DIV_W-1:0] i_div_val;
  logic [NCH-1:0]   o_clk;
  logic [NCH-1:0]   o_tick;
  logic [NCH-1:0]   o_pend;
  logic             o_err;

  vec_t sb[$];
  vec_t tbl[NVEC];
  int   n_checks = 0;
  int   n_pass   = 0;

  clk_divider_mc #(
    .NCH     (NCH),
    .DIV_W   (DIV_W),
    .DEF_DIV (50)
  ) dut (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_en      (i_en),
    .i_div_wr  (i_div_wr),
    .i_div_sel (i_div_sel),
    .i_div_val (i_div_val),
    .o_clk     (o_clk),
    .o_tick    (o_tick),
    .o_pend    (o_pend),
    .o_err     (o_err)
  );

  always #5 i_clk = ~i_clk;

  function automatic vec_t mk(input logic rst, input logic [NCH-1:0] en, input logic wr,
                              input logic [SEL_W-1:0] sel, input logic [DIV_W-1:0] val,
                              input logic [NCH-1:0] c, input logic [NCH-1:0] t,
                              input logic [NCH-1:0] p, input logic e);
    vec_t v;
    v.rst = rst; v.en = en; v.wr = wr; v.sel = sel; v.val = val;
    v.e_clk = c; v.e_tick = t; v.e_pend = p; v.e_err = e;
    return v;
  endfunction

  // Divided-clock level at position pos of a period of d cycles.
  function automatic logic pat(input int pos, input int d);
    return pos < ((d + 1) / 2);
  endfunction

  task automatic checkOutput(input string name);
    vec_t e;
    n_checks++;
    if (sb.size() == 0) begin
      $display("[TB] FAIL %s: scoreboard empty", name);
      return;
    end
    e = sb.pop_front();
    if (o_clk === e.e_clk && o_tick === e.e_tick && o_pend === e.e_pend && o_err === e.e_err) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got clk=%b tick=%b pend=%b err=%b, required clk=%b tick=%b pend=%b err=%b",
               name, o_clk, o_tick, o_pend, o_err, e.e_clk, e.e_tick, e.e_pend, e.e_err);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input string name);
    i_reset   = v.rst;
    i_en      = v.en;
    i_div_wr  = v.wr;
    i_div_sel = v.sel;
    i_div_val = v.val;
    sb.push_back(v);
    @(posedge i_clk);
    #1;
    checkOutput(name);
  endtask

  task automatic doReset(input string name);
    applyStimulus(mk(1'b1, '0, 1'b0, '0, '0, '0, '0, '0, 1'b0), name);
  endtask

  initial begin
    vec_t v;
    logic [NCH-1:0] c, t, p;
    int pos;

    i_reset = 1'b0; i_en = '0; i_div_wr = 1'b0; i_div_sel = '0; i_div_val = '0;
    @(negedge i_clk);

    // Table: invalid writes, idle ratio load, running write, stop at boundary.
    tbl[0]  = mk(0, 6'h00, 1, 3'd1, 8'd1, 6'h00, 6'h00, 6'h00, 1);
    tbl[1]  = mk(0, 6'h00, 1, 3'd6, 8'd5, 6'h00, 6'h00, 6'h00, 1);
    tbl[2]  = mk(0, 6'h00, 1, 3'd7, 8'd9, 6'h00, 6'h00, 6'h00, 1);
    tbl[3]  = mk(0, 6'h00, 1, 3'd2, 8'd2, 6'h00, 6'h00, 6'h00, 0);
    tbl[4]  = mk(0, 6'h04, 0, 3'd0, 8'd0, 6'h04, 6'h04, 6'h00, 0);
    tbl[5]  = mk(0, 6'h04, 0, 3'd0, 8'd0, 6'h00, 6'h00, 6'h00, 0);
    tbl[6]  = mk(0, 6'h04, 0, 3'd0, 8'd0, 6'h04, 6'h04, 6'h00, 0);
    tbl[7]  = mk(0, 6'h04, 1, 3'd2, 8'd3, 6'h00, 6'h00, 6'h04, 0);
    tbl[8]  = mk(0, 6'h04, 0, 3'd0, 8'd0, 6'h04, 6'h04, 6'h00, 0);
    tbl[9]  = mk(0, 6'h04, 1, 3'd7, 8'd9, 6'h04, 6'h00, 6'h00, 1);
    tbl[10] = mk(0, 6'h04, 1, 3'd0, 8'd0, 6'h00, 6'h00, 6'h00, 1);
    tbl[11] = mk(0, 6'h00, 0, 3'd0, 8'd0, 6'h00, 6'h00, 6'h00, 0);
    tbl[12] = mk(0, 6'h00, 0, 3'd0, 8'd0, 6'h00, 6'h00, 6'h00, 0);
    tbl[13] = mk(0, 6'h04, 0, 3'd0, 8'd0, 6'h04, 6'h04, 6'h00, 0);

    doReset("reset_initial");
    for (int i = 0; i < NVEC; i++) applyStimulus(tbl[i], $sformatf("table_%0d", i));

    // Default ratio on channel 0, every other channel quiet.
    doReset("reset_a");
    for (int i = 0; i < 110; i++) begin
      pos = i % 50;
      c = '0; t = '0;
      c[0] = pat(pos, 50); t[0] = (pos == 0);
      applyStimulus(mk(0, 6'h01, 0, '0, '0, c, t, '0, 0), $sformatf("def_div_cyc%0d", i));
    end

    // Idle write of D=5 to channel 1 is applied directly.
    doReset("reset_b");
    applyStimulus(mk(0, 6'h00, 1, 3'd1, 8'd5, '0, '0, '0, 0), "idle_write_d5");
    for (int i = 0; i < 15; i++) begin
      pos = i % 5;
      c = '0; t = '0;
      c[1] = pat(pos, 5); t[1] = (pos == 0);
      applyStimulus(mk(0, 6'h02, 0, '0, '0, c, t, '0, 0), $sformatf("d5_cyc%0d", i));
    end

    // Running write of D=4 waits for the period boundary.
    doReset("reset_c");
    for (int i = 0; i < 62; i++) begin
      c = '0; t = '0; p = '0;
      if (i < 50) begin
        c[0] = pat(i, 50); t[0] = (i == 0); p[0] = (i >= 10);
      end else begin
        pos = (i - 50) % 4;
        c[0] = pat(pos, 4); t[0] = (pos == 0);
      end
      applyStimulus(mk(0, 6'h01, (i == 10), 3'd0, 8'd4, c, t, p, 0), $sformatf("pend_d4_cyc%0d", i));
    end

    // Dropping enable mid-high finishes the period; re-raising before the end is seamless.
    doReset("reset_d");
    for (int i = 0; i < 60; i++) begin
      c = '0; t = '0;
      if (i < 50) begin
        c[0] = pat(i, 50); t[0] = (i == 0);
      end
      v = mk(0, (i < 12) ? 6'h01 : 6'h00, 0, '0, '0, c, t, '0, 0);
      applyStimulus(v, $sformatf("stop_cyc%0d", i));
    end
    for (int j = 0; j < 100; j++) begin
      pos = j % 50;
      c = '0; t = '0;
      c[0] = pat(pos, 50); t[0] = (pos == 0);
      v = mk(0, (j >= 30 && j < 45) ? 6'h00 : 6'h01, 0, '0, '0, c, t, '0, 0);
      applyStimulus(v, $sformatf("reenable_cyc%0d", j));
    end

    // Reset mid-period with a pending ratio discards it.
    doReset("reset_e");
    for (int i = 0; i < 20; i++) begin
      c = '0; t = '0; p = '0;
      c[0] = pat(i, 50); t[0] = (i == 0); p[0] = (i >= 5);
      applyStimulus(mk(0, 6'h01, (i == 5), 3'd0, 8'd7, c, t, p, 0), $sformatf("pre_rst_cyc%0d", i));
    end
    applyStimulus(mk(1, 6'h01, 1, 3'd0, 8'd9, '0, '0, '0, 0), "mid_period_reset");
    for (int i = 0; i < 60; i++) begin
      pos = i % 50;
      c = '0; t = '0;
      c[0] = pat(pos, 50); t[0] = (pos == 0);
      applyStimulus(mk(0, 6'h01, 0, '0, '0, c, t, '0, 0), $sformatf("post_rst_cyc%0d", i));
    end

    // Maximum ratio on channel 5 wraps cleanly.
    doReset("reset_f");
    applyStimulus(mk(0, 6'h00, 1, 3'd5, 8'd255, '0, '0, '0, 0), "idle_write_d255");
    for (int i = 0; i < 260; i++) begin
      pos = i % 255;
      c = '0; t = '0;
      c[5] = pat(pos, 255); t[5] = (pos == 0);
      applyStimulus(mk(0, 6'h20, 0, '0, '0, c, t, '0, 0), $sformatf("d255_cyc%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
